// File: rtl/calc_sequencer.sv
// ============================================================================
// calc_sequencer -- keypad-entry sequencer driving an external combinational
// two-operand calculator ALU and capturing its result after a settle time.
// Rev 1.0
// ============================================================================
`default_nettype none

module calc_sequencer #(
    parameter logic [4:0] ZERO_CODE = 5'd0,
    parameter int         ALU_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [1:0]  key_kind,
    input  logic [4:0]  key_data,
    input  logic [13:0] alu_result,
    output logic [9:0]  alu_a,
    output logic [9:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic [13:0] result,
    output logic        result_valid,
    output logic        error,
    output logic        busy,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ENT_A = 3'd0,
        ENT_B = 3'd1,
        EXEC  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int          c_CW         = $clog2(ALU_LAT + 1);
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(ALU_LAT - 1);
    localparam logic [1:0]  c_KIND_DIGIT = 2'b00;
    localparam logic [1:0]  c_KIND_OP    = 2'b01;
    localparam logic [1:0]  c_KIND_EQ    = 2'b10;
    localparam logic [1:0]  c_KIND_CLR   = 2'b11;
    localparam logic [2:0]  c_OP_ADD     = 3'b000;
    localparam logic [2:0]  c_OP_DIV     = 3'b011;
    localparam logic [2:0]  c_OP_MAX     = 3'b100;
    localparam logic [9:0]  c_ZERO_OPND  = {ZERO_CODE, ZERO_CODE};

    state_t          r_state;
    logic [9:0]      r_a;
    logic [9:0]      r_b;
    logic [2:0]      r_op;
    logic [1:0]      r_cnt_a;
    logic [1:0]      r_cnt_b;
    logic [c_CW-1:0] r_exec_cnt;
    logic [13:0]     r_result;
    logic            r_result_valid;
    logic            r_error;

    logic w_is_digit;
    logic w_is_op;
    logic w_is_eq;
    logic w_is_clr;

    assign w_is_digit = key_valid && (key_kind == c_KIND_DIGIT);
    assign w_is_op    = key_valid && (key_kind == c_KIND_OP) && (key_data[2:0] <= c_OP_MAX);
    assign w_is_eq    = key_valid && (key_kind == c_KIND_EQ);
    assign w_is_clr   = key_valid && (key_kind == c_KIND_CLR);

    // First digit lands in the units slot; a second one shifts it into tens.
    function automatic logic [9:0] f_shift(input logic [9:0] opnd, input logic [1:0] cnt,
                                           input logic [4:0] d);
        return (cnt == 2'd0) ? {ZERO_CODE, d} : {opnd[4:0], d};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ENT_A;
            r_a            <= c_ZERO_OPND;
            r_b            <= c_ZERO_OPND;
            r_op           <= c_OP_ADD;
            r_cnt_a        <= 2'd0;
            r_cnt_b        <= 2'd0;
            r_exec_cnt     <= '0;
            r_result       <= 14'd0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_is_clr) begin
                r_state    <= ENT_A;
                r_a        <= c_ZERO_OPND;
                r_b        <= c_ZERO_OPND;
                r_op       <= c_OP_ADD;
                r_cnt_a    <= 2'd0;
                r_cnt_b    <= 2'd0;
                r_exec_cnt <= '0;
                r_result   <= 14'd0;
                r_error    <= 1'b0;
            end else begin
                case (r_state)
                    ENT_A: begin
                        if (w_is_digit && (r_cnt_a < 2'd2)) begin
                            r_a     <= f_shift(r_a, r_cnt_a, key_data);
                            r_cnt_a <= r_cnt_a + 2'd1;
                        end else if (w_is_op) begin
                            r_op    <= key_data[2:0];
                            r_state <= ENT_B;
                        end
                    end
                    ENT_B: begin
                        if (w_is_digit && (r_cnt_b < 2'd2)) begin
                            r_b     <= f_shift(r_b, r_cnt_b, key_data);
                            r_cnt_b <= r_cnt_b + 2'd1;
                        end else if (w_is_op && (r_cnt_b == 2'd0)) begin
                            r_op <= key_data[2:0];
                        end else if (w_is_eq && (r_cnt_b != 2'd0)) begin
                            r_exec_cnt <= '0;
                            r_state    <= EXEC;
                        end
                    end
                    EXEC: begin
                        if ((r_exec_cnt == '0) && (r_op == c_OP_DIV) && (r_b == c_ZERO_OPND)) begin
                            r_error  <= 1'b1;
                            r_result <= 14'd0;
                            r_state  <= ERR;
                        end else if (r_exec_cnt == c_LAST) begin
                            r_result       <= alu_result;
                            r_result_valid <= 1'b1;
                            r_state        <= DONE;
                        end else begin
                            r_exec_cnt <= r_exec_cnt + 1'b1;
                        end
                    end
                    DONE, ERR: begin
                        // A new digit starts a fresh calculation; the last result stays visible.
                        if (w_is_digit) begin
                            r_a     <= {ZERO_CODE, key_data};
                            r_b     <= c_ZERO_OPND;
                            r_op    <= c_OP_ADD;
                            r_cnt_a <= 2'd1;
                            r_cnt_b <= 2'd0;
                            r_error <= 1'b0;
                            r_state <= ENT_A;
                        end
                    end
                    default: r_state <= ENT_A;
                endcase
            end
        end
    end

    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_op       = r_op;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign error        = r_error;
    assign busy         = (r_state == EXEC);
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// tb_calc_sequencer -- directed, table-driven bench with a behavioural ALU.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

    localparam logic [1:0] K_DIG = 2'b00;
    localparam logic [1:0] K_OP  = 2'b01;
    localparam logic [1:0] K_EQ  = 2'b10;
    localparam logic [1:0] K_CLR = 2'b11;
    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [1:0]  key_kind = 2'b00;
    logic [4:0]  key_data = 5'd0;
    logic [13:0] alu_result;
    logic [9:0]  alu_a;
    logic [9:0]  alu_b;
    logic [2:0]  alu_op;
    logic [13:0] result;
    logic        result_valid;
    logic        error;
    logic        busy;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    calc_sequencer #(.ZERO_CODE(5'd0), .ALU_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_kind     (key_kind),
        .key_data     (key_data),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .result       (result),
        .result_valid (result_valid),
        .error        (error),
        .busy         (busy),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: digit code equals digit value.
    function automatic logic [13:0] alu_model(input logic [9:0] a, input logic [9:0] b,
                                              input logic [2:0] op);
        int va;
        int vb;
        int acc;
        va = int'(a[9:5]) * 10 + int'(a[4:0]);
        vb = int'(b[9:5]) * 10 + int'(b[4:0]);
        case (op)
            3'b000: return 14'(va + vb);
            3'b001: return 14'(va - vb);
            3'b010: return 14'(va * vb);
            3'b011: return (vb == 0) ? 14'd0 : 14'(va / vb);
            3'b100: begin
                acc = 1;
                for (int i = 0; i < vb; i++) acc = (acc * va) % 16384;
                return 14'(acc);
            end
            default: return 14'd0;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  data;
        logic [2:0]  st;
        logic [9:0]  a;
        logic [9:0]  b;
        logic [2:0]  op;
        logic        err;
        logic [13:0] res;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [9:0] enc(input int t, input int u);
        return {t[4:0], u[4:0]};
    endfunction

    function automatic void add(input logic [1:0] k, input logic [4:0] d, input logic [2:0] st,
                                input logic [9:0] a, input logic [9:0] b, input logic [2:0] op,
                                input logic err, input logic [13:0] res);
        vec_t v;
        v.kind = k; v.data = d; v.st = st; v.a = a; v.b = b; v.op = op; v.err = err; v.res = res;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic press(input logic [1:0] k, input logic [4:0] d);
        @(negedge clk);
        key_valid = 1'b1; key_kind = k; key_data = d;
        @(negedge clk);
        key_valid = 1'b0; key_kind = 2'b00; key_data = 5'd0;
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            press(tbl[i].kind, tbl[i].data);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("v%0d_alu_a", i), 32'(alu_a), 32'(tbl[i].a));
            chk($sformatf("v%0d_alu_b", i), 32'(alu_b), 32'(tbl[i].b));
            chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(tbl[i].op));
            chk($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].err));
            chk($sformatf("v%0d_result", i), 32'(result), 32'(tbl[i].res));
            chk($sformatf("v%0d_rvalid", i), 32'(result_valid), 32'd0);
        end
    endtask

    // Equals then watch the two busy cycles and the capture pulse on the third.
    task automatic exec_check(input string nm, input logic [13:0] exp_res);
        press(K_EQ, 5'd0);
        chk({nm, "_c1_state"}, 32'(state), 32'(S_EXEC));
        chk({nm, "_c1_busy"}, 32'(busy), 32'd1);
        chk({nm, "_c1_rvalid"}, 32'(result_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_c2_busy"}, 32'(busy), 32'd1);
        chk({nm, "_c2_rvalid"}, 32'(result_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_c3_rvalid"}, 32'(result_valid), 32'd1);
        chk({nm, "_c3_result"}, 32'(result), 32'(exp_res));
        chk({nm, "_c3_state"}, 32'(state), 32'(S_DONE));
        chk({nm, "_c3_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({nm, "_c4_rvalid"}, 32'(result_valid), 32'd0);
        chk({nm, "_c4_result"}, 32'(result), 32'(exp_res));
    endtask

    int seg[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // seg0: 2, op110 (bad), = (ignored), pow, 1, 0, 5 (3rd ignored), add (ignored)
        seg[0] = tbl.size();
        add(K_DIG, 5'd2, S_A, enc(0,2), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_OP,  5'd6, S_A, enc(0,2), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_EQ,  5'd0, S_A, enc(0,2), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_OP,  5'd4, S_B, enc(0,2), 10'd0, 3'd4, 1'b0, 14'd0);
        add(K_DIG, 5'd1, S_B, enc(0,2), enc(0,1), 3'd4, 1'b0, 14'd0);
        add(K_DIG, 5'd0, S_B, enc(0,2), enc(1,0), 3'd4, 1'b0, 14'd0);
        add(K_DIG, 5'd5, S_B, enc(0,2), enc(1,0), 3'd4, 1'b0, 14'd0);
        add(K_OP,  5'd0, S_B, enc(0,2), enc(1,0), 3'd4, 1'b0, 14'd0);
        // seg1: DONE ignores op/=, digit restarts; 12 + 34
        seg[1] = tbl.size();
        add(K_OP,  5'd1, S_DONE, enc(0,2), enc(1,0), 3'd4, 1'b0, 14'd1024);
        add(K_EQ,  5'd0, S_DONE, enc(0,2), enc(1,0), 3'd4, 1'b0, 14'd1024);
        add(K_DIG, 5'd1, S_A, enc(0,1), 10'd0, 3'd0, 1'b0, 14'd1024);
        add(K_DIG, 5'd2, S_A, enc(1,2), 10'd0, 3'd0, 1'b0, 14'd1024);
        add(K_OP,  5'd0, S_B, enc(1,2), 10'd0, 3'd0, 1'b0, 14'd1024);
        add(K_DIG, 5'd3, S_B, enc(1,2), enc(0,3), 3'd0, 1'b0, 14'd1024);
        add(K_DIG, 5'd4, S_B, enc(1,2), enc(3,4), 3'd0, 1'b0, 14'd1024);
        // seg2: 9,8,7, mul, sub, = (ignored), 9, add (ignored)
        seg[2] = tbl.size();
        add(K_DIG, 5'd9, S_A, enc(0,9), 10'd0, 3'd0, 1'b0, 14'd46);
        add(K_DIG, 5'd8, S_A, enc(9,8), 10'd0, 3'd0, 1'b0, 14'd46);
        add(K_DIG, 5'd7, S_A, enc(9,8), 10'd0, 3'd0, 1'b0, 14'd46);
        add(K_OP,  5'd2, S_B, enc(9,8), 10'd0, 3'd2, 1'b0, 14'd46);
        add(K_OP,  5'd1, S_B, enc(9,8), 10'd0, 3'd1, 1'b0, 14'd46);
        add(K_EQ,  5'd0, S_B, enc(9,8), 10'd0, 3'd1, 1'b0, 14'd46);
        add(K_DIG, 5'd9, S_B, enc(9,8), enc(0,9), 3'd1, 1'b0, 14'd46);
        add(K_OP,  5'd0, S_B, enc(9,8), enc(0,9), 3'd1, 1'b0, 14'd46);
        // seg3: 7 div 0
        seg[3] = tbl.size();
        add(K_DIG, 5'd7, S_A, enc(0,7), 10'd0, 3'd0, 1'b0, 14'd89);
        add(K_OP,  5'd3, S_B, enc(0,7), 10'd0, 3'd3, 1'b0, 14'd89);
        add(K_DIG, 5'd0, S_B, enc(0,7), 10'd0, 3'd3, 1'b0, 14'd89);
        // seg4: ERR ignores op/=, digit 5 recovers; 5 + 3
        seg[4] = tbl.size();
        add(K_OP,  5'd0, S_ERR, enc(0,7), 10'd0, 3'd3, 1'b1, 14'd0);
        add(K_EQ,  5'd0, S_ERR, enc(0,7), 10'd0, 3'd3, 1'b1, 14'd0);
        add(K_DIG, 5'd5, S_A, enc(0,5), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_OP,  5'd0, S_B, enc(0,5), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_DIG, 5'd3, S_B, enc(0,5), enc(0,3), 3'd0, 1'b0, 14'd0);
        // seg5: 3 pow 2 (to be cleared mid-EXEC)
        seg[5] = tbl.size();
        add(K_DIG, 5'd3, S_A, enc(0,3), 10'd0, 3'd0, 1'b0, 14'd8);
        add(K_OP,  5'd4, S_B, enc(0,3), 10'd0, 3'd4, 1'b0, 14'd8);
        add(K_DIG, 5'd2, S_B, enc(0,3), enc(0,2), 3'd4, 1'b0, 14'd8);
        // seg6: clear in ENT_B, then 4 + 1
        seg[6] = tbl.size();
        add(K_DIG, 5'd4, S_A, enc(0,4), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_OP,  5'd2, S_B, enc(0,4), 10'd0, 3'd2, 1'b0, 14'd0);
        add(K_DIG, 5'd6, S_B, enc(0,4), enc(0,6), 3'd2, 1'b0, 14'd0);
        add(K_CLR, 5'd0, S_A, 10'd0, 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_DIG, 5'd4, S_A, enc(0,4), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_OP,  5'd0, S_B, enc(0,4), 10'd0, 3'd0, 1'b0, 14'd0);
        add(K_DIG, 5'd1, S_B, enc(0,4), enc(0,1), 3'd0, 1'b0, 14'd0);
        // seg7: start entry before the async reset
        seg[7] = tbl.size();
        add(K_DIG, 5'd7, S_A, enc(0,7), 10'd0, 3'd0, 1'b0, 14'd5);
        seg[8] = tbl.size();

        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_A));
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        run_table(seg[0], seg[1]);
        exec_check("pow2_10", 14'd1024);
        run_table(seg[1], seg[2]);
        exec_check("add12_34", 14'd46);
        run_table(seg[2], seg[3]);
        exec_check("sub98_9", 14'd89);
        run_table(seg[3], seg[4]);

        press(K_EQ, 5'd0);
        chk("dz_c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("dz_c2_state", 32'(state), 32'(S_ERR));
        chk("dz_c2_error", 32'(error), 32'd1);
        chk("dz_c2_result", 32'(result), 32'd0);
        chk("dz_c2_rvalid", 32'(result_valid), 32'd0);
        chk("dz_c2_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("dz_c3_rvalid", 32'(result_valid), 32'd0);
        chk("dz_c3_error", 32'(error), 32'd1);

        run_table(seg[4], seg[5]);
        exec_check("add5_3", 14'd8);
        run_table(seg[5], seg[6]);

        // Clear one cycle after equals abandons the pending capture.
        press(K_EQ, 5'd0);
        chk("clr_c1_busy", 32'(busy), 32'd1);
        key_valid = 1'b1; key_kind = K_CLR; key_data = 5'd0;
        @(negedge clk);
        key_valid = 1'b0; key_kind = 2'b00;
        chk("clr_state", 32'(state), 32'(S_A));
        chk("clr_result", 32'(result), 32'd0);
        chk("clr_rvalid", 32'(result_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_alu_a", 32'(alu_a), 32'd0);
        chk("clr_alu_b", 32'(alu_b), 32'd0);
        chk("clr_alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("clr_late_rvalid%0d", i), 32'(result_valid), 32'd0);
            chk($sformatf("clr_late_result%0d", i), 32'(result), 32'd0);
        end

        run_table(seg[6], seg[7]);
        exec_check("add4_1", 14'd5);
        run_table(seg[7], seg[8]);

        // Asynchronous reset mid-entry, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'(S_A));
        chk("arst_alu_a", 32'(alu_a), 32'd0);
        chk("arst_alu_b", 32'(alu_b), 32'd0);
        chk("arst_alu_op", 32'(alu_op), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", 32'(state), 32'(S_A));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
